// File: rtl/micro_ucr_hash_ctrl_trabajo_if.sv
// Host-side bundle for the hash job controller: job submission and result return handshakes.
interface micro_ucr_hash_ctrl_trabajo_if;
  logic        trabajo_valido;
  logic        trabajo_listo;
  logic [95:0] trabajo_datos;
  logic [7:0]  trabajo_target;
  logic [31:0] trabajo_nonce_base;
  logic        resultado_valido;
  logic        resultado_listo;
  logic [23:0] resultado_bounty;
  logic        resultado_timeout;
  logic [31:0] resultado_ciclos;
  logic        ocupado;

  modport master (
    output trabajo_valido, trabajo_datos, trabajo_target, trabajo_nonce_base, resultado_listo,
    input  trabajo_listo, resultado_valido, resultado_bounty, resultado_timeout,
           resultado_ciclos, ocupado
  );

  modport slave (
    input  trabajo_valido, trabajo_datos, trabajo_target, trabajo_nonce_base, resultado_listo,
    output trabajo_listo, resultado_valido, resultado_bounty, resultado_timeout,
           resultado_ciclos, ocupado
  );
endinterface

// File: rtl/micro_ucr_hash_ctrl_trabajo.sv
// Job controller feeding the micro_ucr_hash_mod miner: load, supervise, return result.
// Define MICRO_UCR_HASH_TIMEOUT_EN to compile in the MAX_CICLOS timeout exit.
module micro_ucr_hash_ctrl_trabajo #(
  parameter int unsigned NUM_BLOQUES_PARALELOS = 4,
  parameter logic [31:0] MAX_CICLOS            = 32'd1_000_000
) (
  input  logic                                clk,
  input  logic                                reset_n,
  micro_ucr_hash_ctrl_trabajo_if.slave        host,
  output logic [95:0]                         bloque_datos,
  output logic [7:0]                          target,
  output logic [32*NUM_BLOQUES_PARALELOS-1:0] nonce_iniciales,
  output logic                                inicio,
  input  logic [23:0]                         bounty_out,
  input  logic                                terminado_out
);
  localparam int unsigned NONCE_W = 32 * NUM_BLOQUES_PARALELOS;

`ifdef MICRO_UCR_HASH_TIMEOUT_EN
  localparam logic TIMEOUT_EN = 1'b1;
`else
  localparam logic TIMEOUT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CARGA     = 2'd1,
    MINANDO   = 2'd2,
    RESULTADO = 2'd3
  } estado_t;

  estado_t              estado_r;
  logic [95:0]          bloque_datos_r;
  logic [7:0]           target_r;
  logic [NONCE_W-1:0]   nonces_r;
  logic                 inicio_r;
  logic                 trabajo_listo_r;
  logic                 ocupado_r;
  logic                 resultado_valido_r;
  logic [23:0]          resultado_bounty_r;
  logic                 resultado_timeout_r;
  logic [31:0]          resultado_ciclos_r;
  logic [31:0]          ciclos_r;
  logic [31:0]          ciclos_next_s;
  logic                 timeout_hit_s;

  // Lane i starts at base + i; the 32-bit add wraps naturally.
  function automatic logic [NONCE_W-1:0] repartir_nonces(input logic [31:0] base);
    logic [NONCE_W-1:0] carriles;
    carriles = {NONCE_W{1'b0}};
    for (int i = 0; i < int'(NUM_BLOQUES_PARALELOS); i++) begin
      carriles[i*32 +: 32] = base + 32'(i);
    end
    return carriles;
  endfunction

  // Saturating count for the current cycle and the timeout compare against it.
  always_comb begin
    ciclos_next_s = ciclos_r;
    timeout_hit_s = 1'b0;
    if (ciclos_r == 32'hFFFF_FFFF) begin
      ciclos_next_s = ciclos_r;
    end else begin
      ciclos_next_s = ciclos_r + 32'd1;
    end
    timeout_hit_s = TIMEOUT_EN && (ciclos_next_s == MAX_CICLOS);
  end

  // Controller FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado_r            <= IDLE;
      bloque_datos_r      <= 96'd0;
      target_r            <= 8'd0;
      nonces_r            <= {NONCE_W{1'b0}};
      inicio_r            <= 1'b1;
      trabajo_listo_r     <= 1'b1;
      ocupado_r           <= 1'b0;
      resultado_valido_r  <= 1'b0;
      resultado_bounty_r  <= 24'd0;
      resultado_timeout_r <= 1'b0;
      resultado_ciclos_r  <= 32'd0;
      ciclos_r            <= 32'd0;
    end else begin
      case (estado_r)
        IDLE: begin
          if (host.trabajo_valido && trabajo_listo_r) begin
            bloque_datos_r  <= host.trabajo_datos;
            target_r        <= host.trabajo_target;
            nonces_r        <= repartir_nonces(host.trabajo_nonce_base);
            ciclos_r        <= 32'd0;
            trabajo_listo_r <= 1'b0;
            ocupado_r       <= 1'b1;
            estado_r        <= CARGA;
          end
        end
        CARGA: begin
          inicio_r <= 1'b0;
          estado_r <= MINANDO;
        end
        MINANDO: begin
          ciclos_r <= ciclos_next_s;
          // A finished miner takes priority over a coincident timeout.
          if (terminado_out) begin
            resultado_bounty_r  <= bounty_out;
            resultado_timeout_r <= 1'b0;
            resultado_ciclos_r  <= ciclos_next_s;
            resultado_valido_r  <= 1'b1;
            inicio_r            <= 1'b1;
            estado_r            <= RESULTADO;
          end else if (timeout_hit_s) begin
            resultado_bounty_r  <= 24'd0;
            resultado_timeout_r <= 1'b1;
            resultado_ciclos_r  <= ciclos_next_s;
            resultado_valido_r  <= 1'b1;
            inicio_r            <= 1'b1;
            estado_r            <= RESULTADO;
          end
        end
        RESULTADO: begin
          if (host.resultado_listo) begin
            resultado_valido_r <= 1'b0;
            trabajo_listo_r    <= 1'b1;
            ocupado_r          <= 1'b0;
            estado_r           <= IDLE;
          end
        end
        default: begin
          estado_r           <= IDLE;
          inicio_r           <= 1'b1;
          trabajo_listo_r    <= 1'b1;
          ocupado_r          <= 1'b0;
          resultado_valido_r <= 1'b0;
        end
      endcase
    end
  end

  assign bloque_datos           = bloque_datos_r;
  assign target                 = target_r;
  assign nonce_iniciales        = nonces_r;
  assign inicio                 = inicio_r;
  assign host.trabajo_listo     = trabajo_listo_r;
  assign host.ocupado           = ocupado_r;
  assign host.resultado_valido  = resultado_valido_r;
  assign host.resultado_bounty  = resultado_bounty_r;
  assign host.resultado_timeout = resultado_timeout_r;
  assign host.resultado_ciclos  = resultado_ciclos_r;
endmodule

// File: tb/tb_micro_ucr_hash_ctrl_trabajo.sv
// Directed bench for micro_ucr_hash_ctrl_trabajo (N=4, MAX_CICLOS=5), both timeout builds.
module tb_micro_ucr_hash_ctrl_trabajo;
  logic          clk = 1'b0;
  logic          reset_n;
  logic [95:0]   bloque_datos;
  logic [7:0]    target;
  logic [127:0]  nonce_iniciales;
  logic          inicio;
  logic [23:0]   bounty_out;
  logic          terminado_out;
  int            n_tests = 0;
  int            n_fail  = 0;

  micro_ucr_hash_ctrl_trabajo_if hif ();

  micro_ucr_hash_ctrl_trabajo #(
    .NUM_BLOQUES_PARALELOS(4),
    .MAX_CICLOS(32'd5)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .host(hif),
    .bloque_datos(bloque_datos),
    .target(target),
    .nonce_iniciales(nonce_iniciales),
    .inicio(inicio),
    .bounty_out(bounty_out),
    .terminado_out(terminado_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [95:0]  datos;
    logic [7:0]   tgt;
    logic [31:0]  base;
    int           term;
    logic [23:0]  bounty;
    logic [127:0] exp_lanes;
    logic [23:0]  exp_bounty;
    logic         exp_timeout;
    logic [31:0]  exp_ciclos;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " trabajo_listo"}, hif.trabajo_listo, 1'b1);
    check({tag, " inicio"}, inicio, 1'b1);
    check({tag, " ocupado"}, hif.ocupado, 1'b0);
    check({tag, " resultado_valido"}, hif.resultado_valido, 1'b0);
  endtask

  // Returns at the negedge of the CARGA cycle.
  task automatic send_job(input logic [95:0] d, input logic [7:0] t, input logic [31:0] b);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!hif.trabajo_listo && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!hif.trabajo_listo) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_job: trabajo_listo never rose");
    end
    hif.trabajo_valido     = 1'b1;
    hif.trabajo_datos      = d;
    hif.trabajo_target     = t;
    hif.trabajo_nonce_base = b;
    @(posedge clk);
    @(negedge clk);
    hif.trabajo_valido = 1'b0;
    check("carga inicio", inicio, 1'b1);
    check("carga ocupado", hif.ocupado, 1'b1);
    check("carga trabajo_listo", hif.trabajo_listo, 1'b0);
  endtask

  // Miner model: raises terminado_out on the term-th inicio-low cycle (term 0 = never).
  task automatic mine(input int term, input logic [23:0] b, input int limit,
                      output bit got, output int lows);
    got  = 1'b0;
    lows = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (hif.resultado_valido) begin
        got = 1'b1;
        break;
      end
      if (!inicio) lows++;
      if (term != 0 && lows == term) begin
        terminado_out = 1'b1;
        bounty_out    = b;
      end else begin
        terminado_out = 1'b0;
        bounty_out    = 24'h5A5A5A;
      end
      @(posedge clk);
    end
    terminado_out = 1'b0;
  endtask

  task automatic accept_result();
    hif.resultado_listo = 1'b1;
    @(posedge clk);
    @(negedge clk);
    hif.resultado_listo = 1'b0;
    check_idle("post-accept");
  endtask

  initial begin
    bit           got;
    int           lows;
    logic [23:0]  sv_bounty;
    logic [31:0]  sv_ciclos;
    logic         sv_to;
    logic [95:0]  sv_datos;

    vecs[0] = '{96'h1, 8'h10, 32'h0000_0100, 7, 24'hABCDEF,
                128'h00000103_00000102_00000101_00000100,
`ifdef MICRO_UCR_HASH_TIMEOUT_EN
                24'h000000, 1'b1, 32'd5};
`else
                24'hABCDEF, 1'b0, 32'd7};
`endif
    vecs[1] = '{96'hDEADBEEF_01234567_89ABCDEF, 8'h05, 32'hFFFF_FFFE, 3, 24'h123456,
                128'h00000001_00000000_FFFFFFFF_FFFFFFFE, 24'h123456, 1'b0, 32'd3};
    vecs[2] = '{96'hA5A5A5A5_5A5A5A5A_0F0F0F0F, 8'hFF, 32'h7FFF_FFFF, 5, 24'h000042,
                128'h80000002_80000001_80000000_7FFFFFFF, 24'h000042, 1'b0, 32'd5};
    vecs[3] = '{96'h0, 8'h00, 32'h0000_0000, 1, 24'hFFFFFF,
                128'h00000003_00000002_00000001_00000000, 24'hFFFFFF, 1'b0, 32'd1};

    reset_n                = 1'b0;
    hif.trabajo_valido     = 1'b0;
    hif.trabajo_datos      = 96'd0;
    hif.trabajo_target     = 8'd0;
    hif.trabajo_nonce_base = 32'd0;
    hif.resultado_listo    = 1'b0;
    bounty_out             = 24'd0;
    terminado_out          = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_idle("reset");
    check("reset bounty", hif.resultado_bounty, 24'd0);
    check("reset ciclos", hif.resultado_ciclos, 32'd0);
    check("reset nonces", nonce_iniciales, 128'd0);
    check("reset datos", bloque_datos, 96'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check_idle("post-reset");

    for (int v = 0; v < 4; v++) begin
      send_job(vecs[v].datos, vecs[v].tgt, vecs[v].base);
      check($sformatf("v%0d lanes", v), nonce_iniciales, vecs[v].exp_lanes);
      check($sformatf("v%0d datos", v), bloque_datos, vecs[v].datos);
      check($sformatf("v%0d target", v), target, vecs[v].tgt);
      mine(vecs[v].term, vecs[v].bounty, 50, got, lows);
      check($sformatf("v%0d got result", v), got, 1'b1);
      check($sformatf("v%0d inicio-low cycles", v), lows, vecs[v].exp_ciclos);
      check($sformatf("v%0d bounty", v), hif.resultado_bounty, vecs[v].exp_bounty);
      check($sformatf("v%0d timeout", v), hif.resultado_timeout, vecs[v].exp_timeout);
      check($sformatf("v%0d ciclos", v), hif.resultado_ciclos, vecs[v].exp_ciclos);
      accept_result();
    end

    // Backpressure: result held 10 cycles while the host pokes a new job and the miner chatters.
    sv_datos = 96'h0000_1111_2222_3333_4444_5555;
    send_job(sv_datos, 8'h22, 32'h10);
    mine(2, 24'h111111, 50, got, lows);
    check("bp got result", got, 1'b1);
    sv_bounty = 24'h111111;
    sv_ciclos = 32'd2;
    sv_to     = 1'b0;
    for (int c = 0; c < 10; c++) begin
      hif.trabajo_valido = c[0];
      hif.trabajo_datos  = 96'hBAD0 + 96'(c);
      terminado_out      = 1'b1;
      bounty_out         = 24'h777777;
      @(posedge clk);
      @(negedge clk);
      check("bp valido", hif.resultado_valido, 1'b1);
      check("bp bounty", hif.resultado_bounty, sv_bounty);
      check("bp ciclos", hif.resultado_ciclos, sv_ciclos);
      check("bp timeout", hif.resultado_timeout, sv_to);
      check("bp trabajo_listo", hif.trabajo_listo, 1'b0);
      check("bp datos held", bloque_datos, sv_datos);
    end
    terminado_out          = 1'b0;
    hif.trabajo_valido     = 1'b1;
    hif.trabajo_datos      = 96'hC0FFEE;
    hif.trabajo_target     = 8'h33;
    hif.trabajo_nonce_base = 32'h20;
    hif.resultado_listo    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    hif.resultado_listo = 1'b0;
    check("bp listo after accept", hif.trabajo_listo, 1'b1);
    check("bp job not yet taken", bloque_datos, sv_datos);
    @(posedge clk);
    @(negedge clk);
    hif.trabajo_valido = 1'b0;
    check("bp second job datos", bloque_datos, 96'hC0FFEE);
    check("bp second job carga", inicio, 1'b1);
    mine(1, 24'h000033, 50, got, lows);
    check("bp second result", hif.resultado_bounty, 24'h000033);
    accept_result();

    // No terminado_out at all: timeout build exits at MAX_CICLOS, plain build keeps mining.
    send_job(96'h5, 8'h01, 32'h1);
`ifdef MICRO_UCR_HASH_TIMEOUT_EN
    mine(0, 24'h0, 120, got, lows);
    check("to got result", got, 1'b1);
    check("to timeout", hif.resultado_timeout, 1'b1);
    check("to bounty", hif.resultado_bounty, 24'd0);
    check("to ciclos", hif.resultado_ciclos, 32'd5);
    check("to inicio-low cycles", lows, 32'd5);
    accept_result();
    send_job(96'h6, 8'h02, 32'hFFFF_FFFE);
    mine(0, 24'h0, 3, got, lows);
`else
    mine(0, 24'h0, 120, got, lows);
    check("no-to still mining", got, 1'b0);
    check("no-to over 100 cycles", (lows > 100), 1'b1);
    check("no-to timeout flag", hif.resultado_timeout, 1'b0);
`endif

    // Asynchronous abort in the middle of MINANDO.
    check("pre-abort mining", inicio, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle("abort");
    check("abort nonces", nonce_iniciales, 128'd0);
    check("abort datos", bloque_datos, 96'd0);
    check("abort target", target, 8'd0);
    check("abort ciclos", hif.resultado_ciclos, 32'd0);
    check("abort timeout", hif.resultado_timeout, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    send_job(96'h77, 8'h07, 32'hFFFF_FFFF);
    check("after abort lanes", nonce_iniciales, 128'h00000002_00000001_00000000_FFFFFFFF);
    mine(2, 24'h0ABC01, 50, got, lows);
    check("after abort bounty", hif.resultado_bounty, 24'h0ABC01);
    check("after abort ciclos", hif.resultado_ciclos, 32'd2);
    accept_result();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/micro_ucr_hash_ctrl_trabajo.md
# micro_ucr_hash_ctrl_trabajo

Job controller that drives the parallel hash miner (`micro_ucr_hash_mod`) from the host side. It accepts a mining job (data block, target, base nonce) over a valid/ready handshake and fans the base nonce out to the `NUM_BLOQUES_PARALELOS` lanes. It holds the miner in `inicio` while idle, supervises the search with a cycle counter and optional timeout, and returns bounty, cycle count and status over a second valid/ready handshake. It sits between the host/bus interface and the miner's `inicio`/`nonce_iniciales`/`terminado_out`/`bounty_out` pins.

## Interface
Parameters:
- `NUM_BLOQUES_PARALELOS`, default 4: miner lane count; sets the `nonce_iniciales` width.
- `MAX_CICLOS`, default 32'd1_000_000: timeout limit in mining cycles; must be ≥ 1.

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `trabajo_valido` in 1: host job valid.
- `trabajo_listo` out 1: controller ready for a job.
- `trabajo_datos` in 96: job data block.
- `trabajo_target` in 8: job target.
- `trabajo_nonce_base` in 32: first nonce of the job.
- `bloque_datos` out 96: to miner, registered.
- `target` out 8: to miner, registered.
- `nonce_iniciales` out 32*NUM_BLOQUES_PARALELOS: to miner; lane i = base + i, mod 2^32.
- `inicio` out 1: to miner; 1 holds the miner in restart/load.
- `bounty_out` in 24: from miner.
- `terminado_out` in 1: from miner.
- `resultado_valido` out 1: result available.
- `resultado_listo` in 1: host accepts the result.
- `resultado_bounty` out 24: captured bounty; 0 on timeout.
- `resultado_timeout` out 1: 1 means the job ended by timeout.
- `resultado_ciclos` out 32: number of MINANDO cycles consumed.
- `ocupado` out 1: high in any state other than IDLE.

## Operation
The controller is an FSM with four states: IDLE, CARGA, MINANDO and RESULTADO.
- **IDLE**
  - `trabajo_listo`=1, `inicio`=1.
  - On `trabajo_valido`&&`trabajo_listo`: latch `bloque_datos`, `target` and all lanes of `nonce_iniciales`; clear the cycle counter; go to CARGA.
- **CARGA**
  - Exactly one cycle, `inicio`=1, so the miner loads the new operands.
  - Always go to MINANDO.
- **MINANDO**
  - `inicio`=0. The counter increments each cycle, saturating at 2^32-1; the first MINANDO cycle counts as 1.
  - If `terminado_out`=1: capture `bounty_out` and the counter value (including this cycle), set timeout=0, go to RESULTADO.
  - Else, if TIMEOUT is enabled and counter == `MAX_CICLOS`: set bounty=0 and timeout=1, capture the counter, go to RESULTADO.
  - `terminado_out` and timeout in the same cycle: `terminado_out` wins.
- **RESULTADO**
  - `resultado_valido`=1, `inicio`=1 (miner parked). Result outputs are stable.
  - On `resultado_listo`: go to IDLE.
- Lane nonces wrap modulo 2^32. Example: base 32'hFFFF_FFFE with N=4 gives lanes FFFF_FFFE, FFFF_FFFF, 0, 1.
- `trabajo_*` inputs are ignored outside IDLE. `terminado_out` and `bounty_out` are ignored outside MINANDO.

## Timing
- Reset values (async, `reset_n`=0):
  - State IDLE, `inicio`=1, `trabajo_listo`=1, `ocupado`=0.
  - `resultado_valido`=0, `resultado_bounty`=0, `resultado_timeout`=0, `resultado_ciclos`=0.
  - `bloque_datos`=0, `target`=0, `nonce_iniciales`=0.
- A reset in any state aborts the job immediately. No result is produced and the miner is held by `inicio`=1.
- Latencies:
  - Job accept edge → CARGA next cycle (`inicio`=1) → `inicio` falls one cycle later.
  - `terminado_out` sampled high at edge k → `resultado_valido`=1 after edge k.
  - Result accept edge → `trabajo_listo`=1 after that edge.
  - Minimum job-to-job turnaround is 4 cycles.
- All outputs are registered. No combinational path from any input to any output.
- `resultado_valido` and all result data stay stable until accepted. Back-to-back jobs are not overlapped.

## Configuration
- `MICRO_UCR_HASH_TIMEOUT_EN` defined: the timeout comparison against `MAX_CICLOS` is compiled in.
- Not defined: no timeout logic. MINANDO exits only on `terminado_out`, and `resultado_timeout` is tied to 0. The counter still runs and saturates.

## Test plan
- **Nominal job.** Data 96'h1, target 8'h10, base 32'h100, N=4; miner model raises `terminado_out` with bounty 24'hABCDEF on the 7th MINANDO cycle → `nonce_iniciales` = {103,102,101,100}; result bounty ABCDEF, ciclos=7, timeout=0; `inicio` low for exactly 7 cycles.
- **Timeout.** MAX_CICLOS=5 with macro defined, `terminado_out` never asserted → result timeout=1, bounty=0, ciclos=5; without the macro, the FSM stays in MINANDO for more than 100 cycles.
- **Simultaneous events.** MAX_CICLOS=5, `terminado_out`=1 on cycle 5 with bounty 24'h000042 → timeout=0, bounty 000042, ciclos=5.
- **Backpressure.** Hold `resultado_listo`=0 for 10 cycles and toggle `trabajo_valido` with new data → result fields stable, `trabajo_listo`=0, and the second job is accepted only after the result handshake.
- **Wrap and reset.** Base 32'hFFFF_FFFE → lanes {1,0,FFFF_FFFF,FFFF_FFFE}; assert `reset_n`=0 mid-MINANDO → all outputs return to reset values asynchronously and `inicio`=1.
